// File: rtl/brick_pkg.sv
// brick_pkg: FSM state encoding and default playfield geometry for brick_field.
package brick_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, HIT} state_e;
  localparam int DEF_ROWS = 10;
  localparam int DEF_COLS = 14;
  localparam int DEF_ORIGIN_X = 0;
  localparam int DEF_ORIGIN_Y = 30;
  localparam int DEF_BRICK_W = 43;
  localparam int DEF_BRICK_H = 11;
  localparam int DEF_GAP_X = 3;
  localparam int DEF_GAP_Y = 3;
  localparam int DEF_HP_W = 2;
endpackage

// File: rtl/brick_axis_decode.sv
// brick_axis_decode: maps one screen coordinate to a brick slot index along one axis.
module brick_axis_decode
  import brick_pkg::*;
#(
  parameter int COUNT = 14,
  parameter int ORIGIN = 0,
  parameter int SIZE = 43,
  parameter int GAP = 3,
  parameter int IW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic [9:0]    coord_i,
  output logic          inside_o,
  output logic [IW-1:0] index_o
);
  // One range compare per slot; slots never overlap, so at most one matches.
  always_comb begin
    inside_o = 1'b0;
    index_o = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (int'(coord_i) >= ORIGIN + i * (SIZE + GAP) && int'(coord_i) < ORIGIN + i * (SIZE + GAP) + SIZE) begin
        inside_o = 1'b1;
        index_o = IW'(i);
      end
    end
  end
endmodule

// File: rtl/brick_field.sv
// brick_field: per-brick hit-point store with pixel lookup, collision service and level load.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int GAP_X = DEF_GAP_X,
  parameter int GAP_Y = DEF_GAP_Y,
  parameter int HP_W = DEF_HP_W,
  localparam int N = ROWS * COLS,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int BW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      pix_x,
  input  logic [9:0]      pix_y,
  output logic            pix_brick,
  output logic [RW-1:0]   pix_row,
  output logic [CW-1:0]   pix_col,
  output logic [HP_W-1:0] pix_hp,
  input  logic            hit_valid,
  output logic            hit_ready,
  input  logic [9:0]      hit_x,
  input  logic [9:0]      hit_y,
  output logic            hit_done,
  output logic            hit_hit,
  output logic            hit_destroyed,
  output logic [RW-1:0]   hit_row,
  output logic [CW-1:0]   hit_col,
  input  logic            load_start,
  input  logic [N-1:0]    load_mask,
  input  logic [HP_W-1:0] load_hp,
  output logic            load_busy,
  output logic [BW-1:0]   bricks_left,
  output logic            cleared
);
  localparam int IW = $clog2(N);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, pidx, hidx;
  logic [9:0] hx_q, hy_q;
  logic [HP_W-1:0] hp_q [N];
  logic [HP_W-1:0] p_hp, h_hp, load_hp_eff;
  logic px_in, py_in, hx_in, hy_in, p_live, h_live, in_hit, strike, kill;
  logic [RW-1:0] prow, hrow;
  logic [CW-1:0] pcol, hcol;
  brick_axis_decode #(.COUNT(COLS), .ORIGIN(ORIGIN_X), .SIZE(BRICK_W), .GAP(GAP_X), .IW(CW))
    u_pix_x (.coord_i(pix_x), .inside_o(px_in), .index_o(pcol));
  brick_axis_decode #(.COUNT(ROWS), .ORIGIN(ORIGIN_Y), .SIZE(BRICK_H), .GAP(GAP_Y), .IW(RW))
    u_pix_y (.coord_i(pix_y), .inside_o(py_in), .index_o(prow));
  brick_axis_decode #(.COUNT(COLS), .ORIGIN(ORIGIN_X), .SIZE(BRICK_W), .GAP(GAP_X), .IW(CW))
    u_hit_x (.coord_i(hx_q), .inside_o(hx_in), .index_o(hcol));
  brick_axis_decode #(.COUNT(ROWS), .ORIGIN(ORIGIN_Y), .SIZE(BRICK_H), .GAP(GAP_Y), .IW(RW))
    u_hit_y (.coord_i(hy_q), .inside_o(hy_in), .index_o(hrow));
  assign pidx = IW'(prow) * IW'(COLS) + IW'(pcol);
  assign hidx = IW'(hrow) * IW'(COLS) + IW'(hcol);
  assign p_hp = hp_q[pidx];
  assign h_hp = hp_q[hidx];
  assign p_live = px_in & py_in & (|p_hp);
  assign h_live = hx_in & hy_in & (|h_hp);
  assign in_hit = state_q == HIT;
  assign strike = in_hit & h_live;
  assign kill = strike & (h_hp == HP_W'(1));
  assign load_hp_eff = (load_hp == '0) ? HP_W'(1) : load_hp;
  // load_start wins over a same-cycle request, so readiness drops combinationally.
  always_comb begin
    hit_ready = (state_q == IDLE) & ~load_start;
    load_busy = state_q == LOAD;
    state_d = (state_q == IDLE) ? (load_start ? LOAD : (hit_valid ? HIT : IDLE))
            : (state_q == LOAD) ? ((idx_q == IW'(N - 1)) ? IDLE : LOAD)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      hx_q <= '0;
      hy_q <= '0;
      bricks_left <= '0;
      for (int i = 0; i < N; i++) hp_q[i] <= '0;
      pix_brick <= 1'b0;
      pix_row <= '0;
      pix_col <= '0;
      pix_hp <= '0;
      hit_done <= 1'b0;
      hit_hit <= 1'b0;
      hit_destroyed <= 1'b0;
      hit_row <= '0;
      hit_col <= '0;
      cleared <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_brick <= p_live;
      pix_row <= p_live ? prow : '0;
      pix_col <= p_live ? pcol : '0;
      pix_hp <= p_live ? p_hp : '0;
      hit_done <= in_hit;
      cleared <= kill & (bricks_left == BW'(1));
      if (hit_valid && hit_ready) begin
        hx_q <= hit_x;
        hy_q <= hit_y;
      end
      if (state_q == IDLE && load_start) begin
        idx_q <= '0;
        bricks_left <= '0;
      end
      if (state_q == LOAD) begin
        hp_q[idx_q] <= load_mask[idx_q] ? load_hp_eff : '0;
        bricks_left <= bricks_left + BW'(load_mask[idx_q]);
        idx_q <= idx_q + IW'(1);
      end
      if (in_hit) begin
        hit_hit <= h_live;
        hit_destroyed <= kill;
        hit_row <= hrow;
        hit_col <= hcol;
        if (strike) hp_q[hidx] <= h_hp - HP_W'(1);
        if (kill) bricks_left <= bricks_left - BW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && kill) assert (bricks_left != '0);
  end
endmodule

// File: tb/tb_brick_field.sv
// tb_brick_field: scenario tasks with scoreboard queues checking brick_field against a geometry/hp model.
module tb_brick_field;
  localparam int N = 140;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0, hit_x = '0, hit_y = '0;
  logic pix_brick, hit_ready, hit_done, hit_hit, hit_destroyed, load_busy, cleared;
  logic [3:0] pix_row, pix_col, hit_row, hit_col;
  logic [1:0] pix_hp;
  logic hit_valid = 1'b0, load_start = 1'b0;
  logic [N-1:0] load_mask = '0;
  logic [1:0] load_hp = '0;
  logic [7:0] bricks_left;
  int checks = 0, errors = 0;
  int mhp [N];
  int mbl = 0;
  typedef struct {bit b; int r; int c; int hp;} pexp_t;
  typedef struct {bit h; bit d; int r; int c; bit clr; int bl;} hexp_t;
  pexp_t pq[$];
  hexp_t hq[$];

  brick_field dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_brick(pix_brick),
    .pix_row(pix_row), .pix_col(pix_col), .pix_hp(pix_hp), .hit_valid(hit_valid),
    .hit_ready(hit_ready), .hit_x(hit_x), .hit_y(hit_y), .hit_done(hit_done),
    .hit_hit(hit_hit), .hit_destroyed(hit_destroyed), .hit_row(hit_row), .hit_col(hit_col),
    .load_start(load_start), .load_mask(load_mask), .load_hp(load_hp), .load_busy(load_busy),
    .bricks_left(bricks_left), .cleared(cleared)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void geo(input int x, input int y, output bit in, output int r, output int c);
    int cx, cy;
    cx = x;
    cy = y - 30;
    in = cx >= 0 && cy >= 0 && cx / 46 < 14 && cy / 14 < 10 && cx % 46 < 43 && cy % 14 < 11;
    r = in ? cy / 14 : 0;
    c = in ? cx / 46 : 0;
  endfunction

  function automatic hexp_t model_hit(input int x, input int y);
    hexp_t e;
    bit in;
    int r, c, i;
    geo(x, y, in, r, c);
    i = r * 14 + c;
    e.h = in && mhp[i] != 0;
    e.d = e.h && mhp[i] == 1;
    if (e.h) mhp[i]--;
    if (e.d) mbl--;
    e.r = r;
    e.c = c;
    e.clr = e.d && mbl == 0;
    e.bl = mbl;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [N-1:0] mask, input logic [1:0] hp);
    load_mask = mask;
    load_hp = hp;
    load_start = 1'b1;
    mbl = 0;
    for (int i = 0; i < N; i++) begin
      mhp[i] = mask[i] ? ((hp == 0) ? 1 : int'(hp)) : 0;
      mbl += int'(mask[i]);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({pix_brick, hit_ready, hit_done, hit_hit, hit_destroyed, load_busy, cleared} !== 7'b0100000
        || bricks_left !== 8'd0 || {pix_row, pix_col, pix_hp, hit_row, hit_col} !== 18'd0) begin
      errors++;
      $display("FAIL reset_values: got brick=%b ready=%b done=%b busy=%b clr=%b left=%0d, required ready=1 rest 0",
               pix_brick, hit_ready, hit_done, load_busy, cleared, bricks_left);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_load(input logic [N-1:0] mask, input logic [1:0] hp);
    int n;
    start_load(mask, hp);
    tick;
    load_start = 1'b0;
    n = 0;
    while (load_busy === 1'b1 && n < 1000) begin
      tick;
      n++;
    end
    checks++;
    if (n !== N) begin
      errors++;
      $display("FAIL load_length: busy cycles %0d, required %0d", n, N);
    end
    checks++;
    if (bricks_left !== 8'(mbl)) begin
      errors++;
      $display("FAIL load_count: bricks_left %0d, required %0d", bricks_left, mbl);
    end
  endtask

  task automatic test_pixel;
    int xs [7] = '{0, 43, 322, 42, 0, 640, 641};
    int ys [7] = '{30, 30, 128, 40, 41, 156, 156};
    for (int k = 0; k < 7; k++) begin
      pexp_t e;
      bit in;
      int r, c;
      pix_x = 10'(xs[k]);
      pix_y = 10'(ys[k]);
      geo(xs[k], ys[k], in, r, c);
      e.hp = in ? mhp[r * 14 + c] : 0;
      e.b = e.hp != 0;
      e.r = e.b ? r : 0;
      e.c = e.b ? c : 0;
      pq.push_back(e);
      tick;
      e = pq.pop_front();
      checks++;
      if ({pix_brick, pix_row, pix_col, pix_hp} !== {e.b, 4'(e.r), 4'(e.c), 2'(e.hp)}) begin
        errors++;
        $display("FAIL pixel(%0d,%0d): got b=%b r=%0d c=%0d hp=%0d, required b=%b r=%0d c=%0d hp=%0d",
                 xs[k], ys[k], pix_brick, pix_row, pix_col, pix_hp, e.b, e.r, e.c, e.hp);
      end
    end
  endtask

  task automatic test_hits;
    int xs [5] = '{350, 350, 350, 43, 0};
    int ys [5] = '{114, 114, 114, 30, 0};
    test_load('1, 2'd2);
    for (int k = 0; k < 5; k++) begin
      hexp_t e;
      int n;
      hit_x = 10'(xs[k]);
      hit_y = 10'(ys[k]);
      hit_valid = 1'b1;
      #1;
      checks++;
      if (hit_ready !== 1'b1) begin
        errors++;
        $display("FAIL hit_ready_idle: got %b, required 1", hit_ready);
      end
      hq.push_back(model_hit(xs[k], ys[k]));
      tick;
      hit_valid = 1'b0;
      n = 0;
      while (hit_done !== 1'b1 && n < 4) begin
        tick;
        n++;
      end
      e = hq.pop_front();
      checks++;
      if (n !== 1 || {hit_hit, hit_destroyed, cleared} !== {e.h, e.d, e.clr} || bricks_left !== 8'(e.bl)
          || (e.h && {hit_row, hit_col} !== {4'(e.r), 4'(e.c)})) begin
        errors++;
        $display("FAIL hit(%0d,%0d)#%0d: lat=%0d hit=%b des=%b clr=%b r=%0d c=%0d left=%0d, required lat=1 hit=%b des=%b clr=%b r=%0d c=%0d left=%0d",
                 xs[k], ys[k], k, n, hit_hit, hit_destroyed, cleared, hit_row, hit_col, bricks_left,
                 e.h, e.d, e.clr, e.r, e.c, e.bl);
      end
    end
  endtask

  task automatic test_clear;
    hexp_t e;
    int n;
    test_load({1'b1, 139'b0}, 2'd0);
    pix_x = 10'd600;
    pix_y = 10'd160;
    hit_x = 10'd600;
    hit_y = 10'd160;
    hit_valid = 1'b1;
    hq.push_back(model_hit(600, 160));
    tick;
    hit_valid = 1'b0;
    checks++;
    if (pix_brick !== 1'b1 || pix_hp !== 2'd1) begin
      errors++;
      $display("FAIL clear_pixel: got b=%b hp=%0d, required b=1 hp=1", pix_brick, pix_hp);
    end
    n = 0;
    while (hit_done !== 1'b1 && n < 4) begin
      tick;
      n++;
    end
    e = hq.pop_front();
    checks++;
    if (n !== 1 || {hit_hit, hit_destroyed, cleared} !== {e.h, e.d, e.clr} || bricks_left !== 8'(e.bl)
        || {hit_row, hit_col} !== {4'(e.r), 4'(e.c)} || e.clr !== 1'b1) begin
      errors++;
      $display("FAIL clear_hit: lat=%0d hit=%b des=%b clr=%b r=%0d c=%0d left=%0d, required lat=1 hit=1 des=1 clr=1 r=9 c=13 left=0",
               n, hit_hit, hit_destroyed, cleared, hit_row, hit_col, bricks_left);
    end
    tick;
    checks++;
    if ({hit_done, cleared, hit_hit, hit_destroyed, hit_row, hit_col} !== {4'b0011, 4'd9, 4'd13} || pix_brick !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold: done=%b clr=%b hit=%b des=%b r=%0d c=%0d pix=%b, required done=0 clr=0 hit=1 des=1 r=9 c=13 pix=0",
               hit_done, cleared, hit_hit, hit_destroyed, hit_row, hit_col, pix_brick);
    end
  endtask

  task automatic test_priority;
    int n;
    bit seen_done;
    start_load('1, 2'd3);
    hit_valid = 1'b1;
    hit_x = 10'd0;
    hit_y = 10'd30;
    #1;
    checks++;
    if (hit_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got %b, required 0", hit_ready);
    end
    tick;
    load_start = 1'b0;
    hit_valid = 1'b0;
    n = 0;
    seen_done = 1'b0;
    while (load_busy === 1'b1 && n < 1000) begin
      seen_done |= hit_done;
      tick;
      n++;
    end
    checks++;
    if (n !== N || seen_done || hit_done !== 1'b0 || bricks_left !== 8'(mbl)) begin
      errors++;
      $display("FAIL prio_load: busy=%0d done_seen=%b left=%0d, required busy=%0d done_seen=0 left=%0d",
               n, seen_done, bricks_left, N, mbl);
    end
  endtask

  task automatic test_reset_mid;
    pexp_t e;
    start_load('1, 2'd1);
    tick;
    load_start = 1'b0;
    repeat (50) tick;
    checks++;
    if (load_busy !== 1'b1 || bricks_left !== 8'd50) begin
      errors++;
      $display("FAIL midload_state: busy=%b left=%0d, required busy=1 left=50", load_busy, bricks_left);
    end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) mhp[i] = 0;
    mbl = 0;
    #1;
    checks++;
    if (load_busy !== 1'b0 || bricks_left !== 8'd0 || hit_ready !== 1'b1 || hit_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b left=%0d ready=%b done=%b, required busy=0 left=0 ready=1 done=0",
               load_busy, bricks_left, hit_ready, hit_done);
    end
    tick;
    rst_n = 1'b1;
    pix_x = 10'd0;
    pix_y = 10'd30;
    e.b = 1'b0;
    e.r = 0;
    e.c = 0;
    e.hp = 0;
    pq.push_back(e);
    tick;
    e = pq.pop_front();
    checks++;
    if ({pix_brick, pix_row, pix_col, pix_hp} !== {e.b, 4'(e.r), 4'(e.c), 2'(e.hp)} || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_pixel: b=%b hp=%0d busy=%b, required b=0 hp=0 busy=0", pix_brick, pix_hp, load_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mhp[i] = 0;
    repeat (2) tick;
    test_reset;
    test_load('1, 2'd1);
    test_pixel;
    test_hits;
    test_pixel;
    test_clear;
    test_priority;
    test_pixel;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/brick_field.md
# brick_field

Parametrised, stateful successor to the combinational brick-drawing logic. Holds a hit-point counter per brick, answers per-pixel "which brick is here" queries for the VGA renderer, and serves ball-collision requests from the physics block. A collision decrements the brick's hit points and reports destruction. The block also reloads a level from a mask and reports when the field is cleared.

## Interface
Parameters:
- ROWS, 10: brick rows.
- COLS, 14: brick columns.
- ORIGIN_X, 0: left pixel of column 0.
- ORIGIN_Y, 30: top pixel of row 0.
- BRICK_W, 43: brick width in pixels, inclusive span BRICK_W.
- BRICK_H, 11: brick height in pixels.
- GAP_X, 3: horizontal gap between bricks.
- GAP_Y, 3: vertical gap between bricks.
- HP_W, 2: hit-point counter width.

Ports (N = ROWS*COLS, RW = $clog2(ROWS), CW = $clog2(COLS)):
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- pix_x  in  10  renderer pixel x.
- pix_y  in  10  renderer pixel y.
- pix_brick  out  1  registered: a live brick covers (pix_x, pix_y).
- pix_row  out  RW  row of the covered brick; 0 when pix_brick=0.
- pix_col  out  CW  column of the covered brick; 0 when pix_brick=0.
- pix_hp  out  HP_W  hit points of the covered brick; 0 when pix_brick=0.
- hit_valid  in  1  collision request.
- hit_ready  out  1  block can accept a request.
- hit_x  in  10  ball contact x.
- hit_y  in  10  ball contact y.
- hit_done  out  1  one-cycle response strobe.
- hit_hit  out  1  response: a live brick was struck.
- hit_destroyed  out  1  response: the struck brick reached 0 hit points.
- hit_row  out  RW  response row.
- hit_col  out  CW  response column.
- load_start  in  1  begin a level load.
- load_mask  in  N  brick i present when load_mask[i]=1; index = row*COLS+col.
- load_hp  in  HP_W  initial hit points for present bricks. A value of 0 is treated as 1.
- load_busy  out  1  load in progress.
- bricks_left  out  $clog2(N+1)  count of live bricks.
- cleared  out  1  one-cycle pulse when bricks_left goes from 1 to 0 through a hit.

## Operation
- State: hp[N] registers. A brick is live when hp != 0.
- Geometry: column c covers x in [ORIGIN_X + c*(BRICK_W+GAP_X), that + BRICK_W - 1]. Rows use the same rule with Y parameters. Gaps and positions outside the grid belong to no brick.
- Decode uses parallel range compares only, no dividers.
- FSM states:
  - IDLE: hit_ready=1. load_start moves to LOAD with idx=0. load_start has priority over a same-cycle hit_valid; that hit is not accepted and hit_ready is combinationally 0 in that cycle.
  - LOAD: each cycle, hp[idx] = load_mask[idx] ? max(load_hp,1) : 0, and bricks_left increments for each present brick. bricks_left is zeroed on LOAD entry. idx = N-1 returns to IDLE. load_busy=1 and hit_ready=0 throughout. load_start is ignored while in LOAD.
  - HIT: entered when a request is accepted (hit_valid & hit_ready). The request coordinates are registered. One cycle later hit_done=1, and the transition returns to IDLE.
    - If the target brick is live: hp decrements. hit_destroyed=1 when it reaches 0, and bricks_left then decrements. cleared pulses when bricks_left reaches 0.
    - Miss (gap, outside the grid, or dead brick): hit_hit=0, hit_destroyed=0, state unchanged.
- Response fields hold their values until the next hit_done.
- Pixel path is independent of the FSM. It reads current hp; during LOAD it shows partially loaded state.
- bricks_left never wraps. A decrement at 0 is impossible by construction; assert this in simulation.

## Timing
- Reset values: all hp=0, FSM in IDLE, every output 0 except hit_ready=1.
- Pixel latency: 1 clock (pix_* registered from the pix_x/pix_y of the previous cycle).
- Hit: accepted at edge k, hit_done at edge k+1. Throughput is one request per 2 clocks, since hit_ready=0 in HIT.
- Load takes exactly N clocks after acceptance. load_busy rises the cycle after load_start and falls after the N-th write.
- Reset mid-LOAD or mid-HIT: immediate return to reset values. No partial response is emitted.

## Structure
- brick_pkg: FSM state enum (IDLE, LOAD, HIT) and default geometry constants.
- Sub-module brick_axis_decode (parameters: COUNT, ORIGIN, SIZE, GAP). It takes a coordinate and returns `inside` and `index`. Four instances: pixel x, pixel y, hit x, hit y.

## Test plan
- Reset, then load all-ones mask with load_hp=1 -> load_busy high for 140 clocks, bricks_left=140.
- Pixel (0,30) -> pix_brick=1, row 0, col 0 next cycle. Pixel (43,30) (gap) -> pix_brick=0. Pixel (322,128) -> row 7, col 7.
- hit_valid at (350,114) with load_hp=2 -> first response hit_hit=1, destroyed=0, row 6, col 7. Repeat -> destroyed=1 and bricks_left decrements. Third request -> hit_hit=0.
- Load a mask with only bit 139 set, then hit (600,160) -> destroyed=1, bricks_left 1->0, cleared pulses once.
- load_start and hit_valid in the same cycle -> hit_ready=0, no hit_done, LOAD runs.
- rst_n low at LOAD cycle 50 -> all hp=0, bricks_left=0, load_busy=0 asynchronously.
